// File: rtl/byte_unstriping_pkg.sv
// Shared definitions for the two-lane byte unstriper: data width default,
// FSM state encoding and stats counter widths.
package byte_unstriping_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int WORD_CNT_W = 16;
    localparam int ERR_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXP1 = 2'b01,
        EXP0 = 2'b10
    } state_t;

endpackage

// File: rtl/byte_unstriping_stats.sv
// Word and alignment-error counters for the byte unstriper; instantiated only
// when BYTE_UNSTRIPING_STATS_EN is defined.
module byte_unstriping_stats
    import byte_unstriping_pkg::*;
(
    input  logic                  clk_2f,
    input  logic                  reset_L,
    input  logic                  word_evt,
    input  logic                  err_evt,
    output logic [WORD_CNT_W-1:0] word_cnt,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    // word_cnt wraps naturally; err_cnt holds at all-ones
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (word_evt)
                word_cnt <= word_cnt + WORD_CNT_W'(1);
            if (err_evt && (err_cnt != {ERR_CNT_W{1'b1}}))
                err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: rtl/byte_unstriping.sv
// Merges two half-rate lanes back into one full-rate stream (lane 0 first).
// Optional counters are enabled with the BYTE_UNSTRIPING_STATS_EN macro.
module byte_unstriping
    import byte_unstriping_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk_2f,
    input  logic                  reset_L,
    input  logic                  valid_0,
    input  logic [DATA_W-1:0]     lane_0,
    input  logic                  valid_1,
    input  logic [DATA_W-1:0]     lane_1,
    input  logic                  err_clr,
    output logic                  valid_out,
    output logic [DATA_W-1:0]     data_out,
    output logic                  align_err,
    output logic [1:0]            state_dbg
`ifdef BYTE_UNSTRIPING_STATS_EN
    ,
    output logic [WORD_CNT_W-1:0] word_cnt,
    output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

    // Interface: a lane word is taken only in a cycle where its valid is 1 and
    // the FSM expects that lane; there is no backpressure. valid_out=1 marks
    // a merged word on data_out, otherwise data_out is forced to 0.
    state_t state;
    logic   err_evt;

    // lane 1 arriving when lane 0 is expected is an ordering error
    assign err_evt   = valid_1 && !valid_0 && ((state == IDLE) || (state == EXP0));
    assign state_dbg = state;

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            data_out  <= '0;
            align_err <= 1'b0;
        end else begin
            if (err_evt)
                align_err <= 1'b1;
            else if (err_clr)
                align_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (valid_0) begin
                        data_out  <= lane_0;
                        valid_out <= 1'b1;
                        state     <= EXP1;
                    end else begin
                        data_out  <= '0;
                        valid_out <= 1'b0;
                        state     <= IDLE;
                    end
                end
                EXP1: begin
                    if (valid_1) begin
                        data_out  <= lane_1;
                        valid_out <= 1'b1;
                        state     <= EXP0;
                    end else begin
                        data_out  <= '0;
                        valid_out <= 1'b0;
                        state     <= IDLE;
                    end
                end
                EXP0: begin
                    if (valid_0) begin
                        data_out  <= lane_0;
                        valid_out <= 1'b1;
                        state     <= EXP1;
                    end else begin
                        data_out  <= '0;
                        valid_out <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    data_out  <= '0;
                    valid_out <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef BYTE_UNSTRIPING_STATS_EN
    logic word_evt;

    assign word_evt = (state == EXP1) ? valid_1 :
                      ((state == IDLE) || (state == EXP0)) ? valid_0 : 1'b0;

    byte_unstriping_stats u_stats (
        .clk_2f   (clk_2f),
        .reset_L  (reset_L),
        .word_evt (word_evt),
        .err_evt  (err_evt),
        .word_cnt (word_cnt),
        .err_cnt  (err_cnt)
    );
`endif

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: scoreboard queue of expected merged
// words, a negedge monitor, and direct checks of flags and FSM state.
module tb_byte_unstriping;
    import byte_unstriping_pkg::*;

    localparam int W = 32;

    logic          clk_2f  = 1'b0;
    logic          reset_L = 1'b0;
    logic          valid_0 = 1'b0;
    logic          valid_1 = 1'b0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  lane_0  = '0;
    logic [W-1:0]  lane_1  = '0;
    logic          valid_out;
    logic [W-1:0]  data_out;
    logic          align_err;
    logic [1:0]    state_dbg;
`ifdef BYTE_UNSTRIPING_STATS_EN
    logic [15:0]   word_cnt;
    logic [7:0]    err_cnt;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  exp_q[$];

    byte_unstriping #(.DATA_W(W)) dut (
        .clk_2f    (clk_2f),
        .reset_L   (reset_L),
        .valid_0   (valid_0),
        .lane_0    (lane_0),
        .valid_1   (valid_1),
        .lane_1    (lane_1),
        .err_clr   (err_clr),
        .valid_out (valid_out),
        .data_out  (data_out),
        .align_err (align_err),
        .state_dbg (state_dbg)
`ifdef BYTE_UNSTRIPING_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    // clock / reset
    always #5 clk_2f = ~clk_2f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // drive one clk_2f cycle of lane inputs; returns #1 after the sampling edge
    task automatic drive(input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1, input logic clr);
        valid_0 = v0;
        lane_0  = d0;
        valid_1 = v1;
        lane_1  = d1;
        err_clr = clr;
        @(posedge clk_2f);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // scoreboard monitor
    always @(negedge clk_2f) begin
        if (reset_L && valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", data_out);
            end else begin
                check("word", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #12;
        check("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_align_err", {31'd0, align_err}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
        @(negedge clk_2f);
        reset_L = 1'b1;
        idle();

        // invalid lane data is never forwarded
        drive(1'b0, 32'hCAFE_F00D, 1'b0, 32'h1234_5678, 1'b0);
        check("idle_valid_out", {31'd0, valid_out}, 32'd0);
        check("idle_data_out", data_out, 32'd0);

        // even burst A0,A1,A2,A3 with lanes held two cycles
        exp_q.push_back(32'hA000_0000);
        drive(1'b1, 32'hA000_0000, 1'b0, '0, 1'b0);
        exp_q.push_back(32'hA111_1111);
        drive(1'b1, 32'hA000_0000, 1'b1, 32'hA111_1111, 1'b0);
        exp_q.push_back(32'hA222_2222);
        drive(1'b1, 32'hA222_2222, 1'b1, 32'hA111_1111, 1'b0);
        exp_q.push_back(32'hA333_3333);
        drive(1'b1, 32'hA222_2222, 1'b1, 32'hA333_3333, 1'b0);
        idle();
        check("even_end_valid", {31'd0, valid_out}, 32'd0);
        check("even_end_state", {30'd0, state_dbg}, {30'd0, IDLE});
        check("even_align_err", {31'd0, align_err}, 32'd0);
        idle();

        // odd burst 11,22,33
        exp_q.push_back(32'h1111_1111);
        drive(1'b1, 32'h1111_1111, 1'b0, '0, 1'b0);
        exp_q.push_back(32'h2222_2222);
        drive(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b0);
        exp_q.push_back(32'h3333_3333);
        drive(1'b1, 32'h3333_3333, 1'b1, 32'h2222_2222, 1'b0);
        drive(1'b1, 32'h3333_3333, 1'b0, '0, 1'b0);
        check("odd_end_valid", {31'd0, valid_out}, 32'd0);
        check("odd_end_state", {30'd0, state_dbg}, {30'd0, IDLE});
        check("odd_align_err", {31'd0, align_err}, 32'd0);
        idle();

        // orphan lane 1 while idle
        drive(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check("orphan_valid_out", {31'd0, valid_out}, 32'd0);
        check("orphan_align_err", {31'd0, align_err}, 32'd1);
        idle();
        idle();
        check("orphan_sticky", {31'd0, align_err}, 32'd1);
`ifdef BYTE_UNSTRIPING_STATS_EN
        check("orphan_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("orphan_cleared", {31'd0, align_err}, 32'd0);
        idle();

        // reset after the second output word
        exp_q.push_back(32'hB000_0000);
        drive(1'b1, 32'hB000_0000, 1'b0, '0, 1'b0);
        exp_q.push_back(32'hB111_1111);
        drive(1'b1, 32'hB000_0000, 1'b1, 32'hB111_1111, 1'b0);
        @(negedge clk_2f);
        #1;
        reset_L = 1'b0;
        valid_0 = 1'b1;
        lane_0  = 32'hB222_2222;
        valid_1 = 1'b1;
        #1;
        check("midrst_valid_out", {31'd0, valid_out}, 32'd0);
        check("midrst_data_out", data_out, 32'd0);
        check("midrst_state", {30'd0, state_dbg}, {30'd0, IDLE});
        @(negedge clk_2f);
        reset_L = 1'b1;
        drive(1'b0, '0, 1'b1, 32'hB333_3333, 1'b0);
        check("postrst_valid_out", {31'd0, valid_out}, 32'd0);
        check("postrst_align_err", {31'd0, align_err}, 32'd1);
        exp_q.push_back(32'hC000_0000);
        drive(1'b1, 32'hC000_0000, 1'b0, '0, 1'b0);
        check("postrst_word_valid", {31'd0, valid_out}, 32'd1);
        idle();
        check("postrst_end_state", {30'd0, state_dbg}, {30'd0, IDLE});

        // clear and set in the same cycle: set wins
        drive(1'b0, '0, 1'b1, 32'h0BAD_0BAD, 1'b1);
        check("collide_align_err", {31'd0, align_err}, 32'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("clear_align_err", {31'd0, align_err}, 32'd0);
        idle();

`ifdef BYTE_UNSTRIPING_STATS_EN
        // continuous stream of 65537 words wraps word_cnt to 1
        @(negedge clk_2f);
        reset_L = 1'b0;
        #2;
        reset_L = 1'b1;
        for (int k = 0; k < 65537; k++) begin
            exp_q.push_back(k);
            drive(1'b1, k, 1'b1, k, 1'b0);
        end
        idle();
        check("wrap_word_cnt", {16'd0, word_cnt}, 32'd1);
        check("wrap_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("wrap_align_err", {31'd0, align_err}, 32'd0);
`endif

        idle();
        idle();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
